// File: rtl/gcd_job_ctrl.sv
// gcd_job_ctrl: runs one GCD job on an external CPU core per accepted request.
// Each job latches the operands, holds the CPU in reset, stretches the start
// pulse, then waits until the CPU result has been stable long enough.
// Optional feature: define GCD_TIMEOUT_EN to add a WAIT-state watchdog that
// aborts the job with err_code 2'b10 after TIMEOUT_CYCLES clk cycles.
module gcd_job_ctrl #(
  parameter int CLEAR_CYCLES   = 200,
  parameter int START_STRETCH  = 200,
  parameter int STABLE_CNT     = 4,
  parameter int TIMEOUT_CYCLES = 10_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [7:0]  op_a,
  input  logic [7:0]  op_b,
  output logic        cpu_rst_n,
  output logic        cpu_start,
  output logic [31:0] cpu_a,
  output logic [31:0] cpu_b,
  input  logic [31:0] cpu_result,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [31:0] result
);

  // One counter serves both CLEAR and START, so it spans the longer phase.
  localparam int PHASE_MAX = (CLEAR_CYCLES > START_STRETCH) ? CLEAR_CYCLES : START_STRETCH;
  localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
  localparam int STAB_W    = $clog2(STABLE_CNT + 1);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ZERO    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    START,
    WAIT,
    DONE,
    ERR
  } state_t;

  state_t              state;
  logic [PHASE_W-1:0]  phase_cnt;
  logic [STAB_W-1:0]   stab_cnt;
  logic [31:0]         res_meta;
  logic [31:0]         res_sync;
  logic [31:0]         res_prev;
  logic                sample_match;
  logic                qualify;

`ifdef GCD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]    tmo_cnt;
`endif

  // Bring the slow-domain result across with two flops, then keep one more
  // sample so consecutive synchronized values can be compared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_meta <= '0;
      res_sync <= '0;
      res_prev <= '0;
    end else begin
      // NOTE: non-blocking assignments make each flop take the old value of
      // the one before it; blocking here would collapse the chain to one stage.
      res_meta <= cpu_result;
      res_sync <= res_meta;
      res_prev <= res_sync;
    end
  end

  // A sample counts toward stability only if it is non-zero and repeats.
  assign sample_match = (res_sync != '0) && (res_sync == res_prev);
  assign qualify      = sample_match && (stab_cnt == STAB_W'(STABLE_CNT - 1));

  // Job sequencer with all status and CPU-control outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cpu_rst_n <= 1'b0;
      cpu_start <= 1'b0;
      cpu_a     <= '0;
      cpu_b     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      result    <= '0;
      phase_cnt <= '0;
      stab_cnt  <= '0;
`ifdef GCD_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          // CPU is released on the first edge after reset and stays out of
          // reset between jobs.
          cpu_rst_n <= 1'b1;
          if (req) begin
            cpu_a     <= {24'd0, op_a};
            cpu_b     <= {24'd0, op_b};
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            phase_cnt <= '0;
            if (op_a == '0 || op_b == '0) begin
              // A zero operand never reaches the CPU.
              state    <= ERR;
              err      <= 1'b1;
              err_code <= ERR_ZERO;
            end else begin
              state     <= CLEAR;
              cpu_rst_n <= 1'b0;
              busy      <= 1'b1;
            end
          end
        end

        CLEAR: begin
          if (phase_cnt == PHASE_W'(CLEAR_CYCLES - 1)) begin
            phase_cnt <= '0;
            cpu_rst_n <= 1'b1;
            cpu_start <= 1'b1;
            state     <= START;
          end else begin
            phase_cnt <= phase_cnt + PHASE_W'(1);
          end
        end

        START: begin
          if (phase_cnt == PHASE_W'(START_STRETCH - 1)) begin
            phase_cnt <= '0;
            cpu_start <= 1'b0;
            stab_cnt  <= '0;
`ifdef GCD_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
            state     <= WAIT;
          end else begin
            phase_cnt <= phase_cnt + PHASE_W'(1);
          end
        end

        WAIT: begin
          if (qualify) begin
            result   <= res_sync;
            done     <= 1'b1;
            busy     <= 1'b0;
            stab_cnt <= '0;
            state    <= DONE;
          end else begin
            stab_cnt <= sample_match ? stab_cnt + STAB_W'(1) : '0;
`ifdef GCD_TIMEOUT_EN
            if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
              err      <= 1'b1;
              err_code <= ERR_TIMEOUT;
              busy     <= 1'b0;
              state    <= ERR;
            end else begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
`endif
          end
        end

        // NOTE: the two unused encodings fall back to IDLE so a corrupted
        // state register recovers instead of sticking.
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_job_ctrl.sv
// tb_gcd_job_ctrl: directed checks of gcd_job_ctrl with short bench timings.
// The bench plays the CPU by driving cpu_result directly. Build with the same
// GCD_TIMEOUT_EN setting as the RTL.
module tb_gcd_job_ctrl;

  localparam int CLR = 4;
  localparam int STR = 4;
  localparam int STB = 3;
  localparam int TMO = 50;
  // Value driven between edges: two synchronizer flops, one edge to fill the
  // previous-sample register, then STB matching samples.
  localparam int LAT = 2 + 1 + STB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [7:0]  op_a = '0;
  logic [7:0]  op_b = '0;
  logic [31:0] cpu_result = '0;
  logic        cpu_rst_n;
  logic        cpu_start;
  logic [31:0] cpu_a;
  logic [31:0] cpu_b;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  gcd_job_ctrl #(
    .CLEAR_CYCLES   (CLR),
    .START_STRETCH  (STR),
    .STABLE_CNT     (STB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .op_a       (op_a),
    .op_b       (op_b),
    .cpu_rst_n  (cpu_rst_n),
    .cpu_start  (cpu_start),
    .cpu_a      (cpu_a),
    .cpu_b      (cpu_b),
    .cpu_result (cpu_result),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .result     (result)
  );

  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Pulse req for one cycle; called and returns at a negedge.
  task automatic issue_req(input logic [7:0] a, input logic [7:0] b);
    op_a = a;
    op_b = b;
    req  = 1'b1;
    @(negedge clk);
    req  = 1'b0;
  endtask

  // Count cycles cpu_rst_n stays low, then cycles cpu_start stays high.
  task automatic run_to_wait(output int n_clr, output int n_start);
    n_clr = 0;
    while (cpu_rst_n === 1'b0 && n_clr < 100) begin
      n_clr++;
      @(negedge clk);
    end
    n_start = 0;
    while (cpu_start === 1'b1 && n_start < 100) begin
      n_start++;
      @(negedge clk);
    end
  endtask

  // Cycles until done or err rises, bounded by max_cyc.
  task automatic wait_finish(input int max_cyc, output int n);
    n = 0;
    while (!(done === 1'b1 || err === 1'b1) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if ({cpu_rst_n, cpu_start, busy, done, err, err_code} !== 7'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b expected 0000000", {cpu_rst_n, cpu_start, busy, done, err, err_code});
    end
    tests++; if ({cpu_a, cpu_b, result} !== 96'd0) begin
      fails++; $display("FAIL reset_data: got a=%0d b=%0d result=%0d expected all 0", cpu_a, cpu_b, result);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (cpu_rst_n !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_release: got cpu_rst_n=%b busy=%b expected 1 0", cpu_rst_n, busy);
    end
  endtask

  task automatic test_normal_job();
    int nc, ns, n;
    cpu_result = '0;
    issue_req(8'd12, 8'd18);
    tests++; if (busy !== 1'b1 || cpu_rst_n !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL normal_accept: got busy=%b cpu_rst_n=%b done=%b expected 1 0 0", busy, cpu_rst_n, done);
    end
    tests++; if (cpu_a !== 32'd12 || cpu_b !== 32'd18) begin
      fails++; $display("FAIL normal_operands: got %0d %0d expected 12 18", cpu_a, cpu_b);
    end
    run_to_wait(nc, ns);
    tests++; if (nc != CLR) begin
      fails++; $display("FAIL normal_clear_len: got %0d expected %0d", nc, CLR);
    end
    tests++; if (ns != STR) begin
      fails++; $display("FAIL normal_start_len: got %0d expected %0d", ns, STR);
    end
    repeat (20) @(negedge clk);
    tests++; if (busy !== 1'b1 || done !== 1'b0 || cpu_start !== 1'b0 || cpu_rst_n !== 1'b1) begin
      fails++; $display("FAIL normal_waiting: got busy=%b done=%b start=%b rst=%b expected 1 0 0 1", busy, done, cpu_start, cpu_rst_n);
    end
    cpu_result = 32'd6;
    wait_finish(50, n);
    tests++; if (n != LAT) begin
      fails++; $display("FAIL normal_latency: got %0d expected %0d", n, LAT);
    end
    tests++; if (done !== 1'b1 || result !== 32'd6 || busy !== 1'b0 || err !== 1'b0) begin
      fails++; $display("FAIL normal_done: got done=%b result=%0d busy=%b err=%b expected 1 6 0 0", done, result, busy, err);
    end
  endtask

  task automatic test_zero_operand();
    int toggled;
    issue_req(8'd0, 8'd25);
    tests++; if (err !== 1'b1 || err_code !== 2'b01 || done !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL zero_err: got err=%b code=%b done=%b busy=%b expected 1 01 0 0", err, err_code, done, busy);
    end
    tests++; if (cpu_a !== 32'd0 || cpu_b !== 32'd25 || result !== 32'd6) begin
      fails++; $display("FAIL zero_data: got a=%0d b=%0d result=%0d expected 0 25 6", cpu_a, cpu_b, result);
    end
    toggled = (cpu_rst_n !== 1'b1 || cpu_start !== 1'b0) ? 1 : 0;
    repeat (10) begin
      @(negedge clk);
      if (cpu_rst_n !== 1'b1 || cpu_start !== 1'b0) toggled = 1;
    end
    tests++; if (toggled != 0 || err !== 1'b1) begin
      fails++; $display("FAIL zero_cpu_untouched: got toggled=%0d err=%b expected 0 1", toggled, err);
    end
  endtask

  task automatic test_glitch();
    int nc, ns, n;
    cpu_result = '0;
    issue_req(8'd15, 8'd25);
    tests++; if (err !== 1'b0 || err_code !== 2'b00 || busy !== 1'b1) begin
      fails++; $display("FAIL glitch_accept: got err=%b code=%b busy=%b expected 0 00 1", err, err_code, busy);
    end
    run_to_wait(nc, ns);
    cpu_result = 32'd3;
    repeat (3) @(negedge clk);
    cpu_result = 32'd5;
    wait_finish(50, n);
    tests++; if (n != LAT) begin
      fails++; $display("FAIL glitch_latency: got %0d expected %0d", n, LAT);
    end
    tests++; if (done !== 1'b1 || result !== 32'd5) begin
      fails++; $display("FAIL glitch_result: got done=%b result=%0d expected 1 5", done, result);
    end
  endtask

  task automatic test_ignore_req();
    int nc, ns, n;
    cpu_result = '0;
    issue_req(8'd20, 8'd8);
    run_to_wait(nc, ns);
    repeat (3) @(negedge clk);
    issue_req(8'd7, 8'd3);
    tests++; if (cpu_a !== 32'd20 || cpu_b !== 32'd8) begin
      fails++; $display("FAIL ignore_operands: got %0d %0d expected 20 8", cpu_a, cpu_b);
    end
    tests++; if (busy !== 1'b1 || cpu_rst_n !== 1'b1 || cpu_start !== 1'b0) begin
      fails++; $display("FAIL ignore_state: got busy=%b rst=%b start=%b expected 1 1 0", busy, cpu_rst_n, cpu_start);
    end
    cpu_result = 32'd4;
    wait_finish(50, n);
    tests++; if (done !== 1'b1 || result !== 32'd4) begin
      fails++; $display("FAIL ignore_complete: got done=%b result=%0d expected 1 4", done, result);
    end
  endtask

  task automatic test_timeout();
    int nc, ns;
    cpu_result = '0;
    issue_req(8'd9, 8'd6);
    run_to_wait(nc, ns);
`ifdef GCD_TIMEOUT_EN
    repeat (TMO - 1) @(negedge clk);
    tests++; if (err !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL timeout_early: got err=%b busy=%b expected 0 1", err, busy);
    end
    @(negedge clk);
    tests++; if (err !== 1'b1 || err_code !== 2'b10 || busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL timeout_err: got err=%b code=%b busy=%b done=%b expected 1 10 0 0", err, err_code, busy, done);
    end
    tests++; if (result !== 32'd4) begin
      fails++; $display("FAIL timeout_result_held: got %0d expected 4", result);
    end
`else
    begin
      int n;
      repeat (500) @(negedge clk);
      tests++; if (busy !== 1'b1 || err !== 1'b0 || done !== 1'b0 || err_code !== 2'b00) begin
        fails++; $display("FAIL no_timeout_wait: got busy=%b err=%b done=%b code=%b expected 1 0 0 00", busy, err, done, err_code);
      end
      cpu_result = 32'd3;
      wait_finish(50, n);
      tests++; if (done !== 1'b1 || result !== 32'd3) begin
        fails++; $display("FAIL no_timeout_complete: got done=%b result=%0d expected 1 3", done, result);
      end
    end
`endif
  endtask

  task automatic test_reset_mid_job();
    int nc, ns, n;
    cpu_result = '0;
    issue_req(8'd14, 8'd21);
    nc = 0;
    while (cpu_start !== 1'b1 && nc < 100) begin
      nc++;
      @(negedge clk);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++; if ({cpu_rst_n, cpu_start, busy, done, err, err_code} !== 7'b0) begin
      fails++; $display("FAIL midreset_ctrl: got %b expected 0000000", {cpu_rst_n, cpu_start, busy, done, err, err_code});
    end
    tests++; if ({cpu_a, cpu_b, result} !== 96'd0) begin
      fails++; $display("FAIL midreset_data: got a=%0d b=%0d result=%0d expected all 0", cpu_a, cpu_b, result);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (cpu_rst_n !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL midreset_release: got cpu_rst_n=%b busy=%b expected 1 0", cpu_rst_n, busy);
    end
    issue_req(8'd14, 8'd21);
    run_to_wait(nc, ns);
    tests++; if (nc != CLR || ns != STR) begin
      fails++; $display("FAIL midreset_phases: got clear=%0d start=%0d expected %0d %0d", nc, ns, CLR, STR);
    end
    cpu_result = 32'd7;
    wait_finish(50, n);
    tests++; if (done !== 1'b1 || result !== 32'd7) begin
      fails++; $display("FAIL midreset_job: got done=%b result=%0d expected 1 7", done, result);
    end
  endtask

  task automatic test_back_to_back();
    int nc, ns, n;
    cpu_result = '0;
    issue_req(8'd99, 8'd66);
    tests++; if (busy !== 1'b1 || done !== 1'b0 || cpu_rst_n !== 1'b0 || result !== 32'd7) begin
      fails++; $display("FAIL b2b_accept: got busy=%b done=%b rst=%b result=%0d expected 1 0 0 7", busy, done, cpu_rst_n, result);
    end
    run_to_wait(nc, ns);
    tests++; if (result !== 32'd7) begin
      fails++; $display("FAIL b2b_result_held: got %0d expected 7", result);
    end
    cpu_result = 32'd33;
    wait_finish(50, n);
    tests++; if (done !== 1'b1 || result !== 32'd33 || cpu_a !== 32'd99 || cpu_b !== 32'd66) begin
      fails++; $display("FAIL b2b_done: got done=%b result=%0d a=%0d b=%0d expected 1 33 99 66", done, result, cpu_a, cpu_b);
    end
  endtask

  initial begin
    test_reset();
    test_normal_job();
    test_zero_operand();
    test_glitch();
    test_ignore_req();
    test_timeout();
    test_reset_mid_job();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
